// File: rtl/adc_frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : adc_frame_sync
// Description : Re-times left/right ADC words from an asynchronous word clock
//               into stereo frames with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_sync #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             wclkIn,
    input  logic             lrckIn,
    input  logic [WIDTH-1:0] leftIn,
    input  logic [WIDTH-1:0] rightIn,
    output logic [WIDTH-1:0] leftOut,
    output logic [WIDTH-1:0] rightOut,
    output logic             outValid,
    input  logic             outReady,
    output logic             overflow,
    input  logic             clearOverflow
);

    localparam logic [0:0] c_WAIT_LEFT  = 1'b0;
    localparam logic [0:0] c_WAIT_RIGHT = 1'b1;

    logic [SYNC_STAGES-1:0] r_wclk_sync;
    logic [SYNC_STAGES-1:0] r_lrck_sync;
    logic                   r_wclk_prev;
    logic                   r_event;
    logic                   r_event_left;
    logic [0:0]             r_state;
    logic [WIDTH-1:0]       r_hold;

    logic w_fall;
    logic w_complete;
    logic w_drop;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_wclk_sync  <= '0;
            r_lrck_sync  <= '0;
            r_wclk_prev  <= 1'b0;
            r_event      <= 1'b0;
            r_event_left <= 1'b0;
        end else begin
            r_wclk_sync  <= {r_wclk_sync[SYNC_STAGES-2:0], wclkIn};
            r_lrck_sync  <= {r_lrck_sync[SYNC_STAGES-2:0], lrckIn};
            r_wclk_prev  <= r_wclk_sync[SYNC_STAGES-1];
            r_event      <= w_fall;
            r_event_left <= r_lrck_sync[SYNC_STAGES-1];
        end
    end

    // The channel bit travels beside the edge detector so both refer to the same word.
    assign w_fall     = ~r_wclk_sync[SYNC_STAGES-1] & r_wclk_prev;
    assign w_complete = r_event & ~r_event_left & (r_state == c_WAIT_RIGHT);
    assign w_drop     = w_complete & outValid & ~outReady;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= c_WAIT_LEFT;
            r_hold  <= '0;
        end else if (r_event) begin
            if (r_event_left) begin
                r_hold  <= leftIn;
                r_state <= c_WAIT_RIGHT;
            end else if (r_state == c_WAIT_RIGHT) begin
                r_state <= c_WAIT_LEFT;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            leftOut  <= '0;
            rightOut <= '0;
            outValid <= 1'b0;
        end else if (w_complete && (!outValid || outReady)) begin
            leftOut  <= r_hold;
            rightOut <= rightIn;
            outValid <= 1'b1;
        end else if (outValid && outReady) begin
            outValid <= 1'b0;
        end
    end

    // A drop wins over a coincident clear so no lost frame goes unreported.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (w_drop) begin
            overflow <= 1'b1;
        end else if (clearOverflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_frame_sync
// Description : Scoreboard bench for adc_frame_sync (WIDTH=16, SYNC_STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_frame_sync;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         reset = 1'b1;
    logic         wclkIn = 1'b0;
    logic         lrckIn = 1'b0;
    logic [W-1:0] leftIn = '0;
    logic [W-1:0] rightIn = '0;
    logic [W-1:0] leftOut;
    logic [W-1:0] rightOut;
    logic         outValid;
    logic         outReady = 1'b1;
    logic         overflow;
    logic         clearOverflow = 1'b0;

    adc_frame_sync #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .reset(reset), .wclkIn(wclkIn), .lrckIn(lrckIn),
        .leftIn(leftIn), .rightIn(rightIn), .leftOut(leftOut),
        .rightOut(rightOut), .outValid(outValid), .outReady(outReady),
        .overflow(overflow), .clearOverflow(clearOverflow)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail = 0;
    int          frames_seen = 0;
    logic [31:0] exp_q[$];

    logic        m_wr = 1'b0;
    logic [15:0] m_hold = '0;
    logic        m_pending = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Reference channel pairing and drop behaviour.
    task automatic model_word(input bit is_left, input logic [15:0] val, input bit rdy);
        if (is_left) begin
            m_hold = val;
            m_wr   = 1'b1;
        end else if (m_wr) begin
            m_wr = 1'b0;
            if (!m_pending || rdy) begin
                exp_q.push_back({m_hold, val});
                m_pending = 1'b1;
            end
        end
    endtask

    task automatic fall(input bit is_left, input logic [15:0] val);
        wclkIn = 1'b1;
        repeat (8) step();
        lrckIn = is_left;
        if (is_left) begin
            leftIn  = val;
            rightIn = 16'($urandom);
        end else begin
            rightIn = val;
            leftIn  = 16'($urandom);
        end
        wclkIn = 1'b0;
    endtask

    task automatic word(input bit is_left, input logic [15:0] val);
        fall(is_left, val);
        model_word(is_left, val, outReady);
        repeat (8) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wclkIn = 1'b0;
        repeat (3) step();
        check("rst_leftOut", 32'(leftOut), 32'h0);
        check("rst_rightOut", 32'(rightOut), 32'h0);
        check("rst_outValid", 32'(outValid), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        reset = 1'b0;
        m_wr = 1'b0;
        m_pending = 1'b0;
        step();
    endtask

    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [31:0] prev_data = '0;

    always @(negedge CLK) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (outValid && (!prev_valid || prev_hs)) begin
                frames_seen++;
                check("frame_expected", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) check("frame_data", {leftOut, rightOut}, exp_q.pop_front());
            end else if (outValid && prev_valid) begin
                check("frame_hold", {leftOut, rightOut}, prev_data);
            end
            prev_valid = outValid;
            prev_hs = outValid && outReady;
            prev_data = {leftOut, rightOut};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int f0;
        // Basic frame and latency from the right-word falling edge.
        do_reset();
        outReady = 1'b1;
        word(1'b1, 16'h1234);
        f0 = frames_seen;
        fall(1'b0, 16'hFEDC);
        model_word(1'b0, 16'hFEDC, 1'b1);
        repeat (3) step();
        check("lat_before", 32'(outValid), 32'h0);
        step();
        check("lat_at", 32'(outValid), 32'h1);
        repeat (6) step();
        check("basic_one_pulse", 32'(frames_seen - f0), 32'h1);
        check("basic_overflow", 32'(overflow), 32'h0);

        // Stray right word first after reset is discarded.
        do_reset();
        f0 = frames_seen;
        word(1'b0, 16'h7FFF);
        word(1'b1, 16'h8000);
        word(1'b0, 16'h0001);
        check("orphan_frames", 32'(frames_seen - f0), 32'h1);

        // A repeated left word replaces the held sample.
        word(1'b1, 16'h1111);
        word(1'b1, 16'h2222);
        word(1'b0, 16'h3333);
        check("q_empty_relatch", 32'(exp_q.size()), 32'h0);

        // Backpressure: second frame dropped, overflow sticky until cleared.
        do_reset();
        outReady = 1'b0;
        word(1'b1, 16'hA1A1);
        word(1'b0, 16'hB2B2);
        word(1'b1, 16'hC3C3);
        word(1'b0, 16'hD4D4);
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_valid", 32'(outValid), 32'h1);
        clearOverflow = 1'b1;
        step();
        clearOverflow = 1'b0;
        step();
        check("ovf_cleared", 32'(overflow), 32'h0);
        check("ovf_first_kept", {leftOut, rightOut}, 32'hA1A1B2B2);
        outReady = 1'b1;
        repeat (3) step();
        m_pending = 1'b0;
        check("ovf_drained", 32'(outValid), 32'h0);
        check("q_empty_ovf", 32'(exp_q.size()), 32'h0);

        // Reset mid-frame discards the held left sample.
        do_reset();
        f0 = frames_seen;
        fall(1'b1, 16'hAAAA);
        repeat (5) step();
        reset = 1'b1;
        m_wr = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        repeat (8) step();
        word(1'b0, 16'h5555);
        repeat (4) step();
        check("midrst_frames", 32'(frames_seen - f0), 32'h0);
        check("midrst_valid", 32'(outValid), 32'h0);

        // Completion coinciding with acceptance of the presented frame.
        do_reset();
        outReady = 1'b0;
        word(1'b1, 16'h0A0A);
        word(1'b0, 16'h0B0B);
        word(1'b1, 16'h0C0C);
        fall(1'b0, 16'h0D0D);
        model_word(1'b0, 16'h0D0D, 1'b1);
        repeat (3) step();
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        check("coinc_valid", 32'(outValid), 32'h1);
        step();
        check("coinc_data", {leftOut, rightOut}, 32'h0C0C0D0D);
        check("coinc_overflow", 32'(overflow), 32'h0);
        outReady = 1'b1;
        repeat (3) step();
        m_pending = 1'b0;
        check("q_empty_final", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_frame_sync.md
ADC_FRAME_SYNC -- requirements
Module: adc_frame_sync

Interface
- REQ-001: Parameter WIDTH, default 16: sample width in bits.
- REQ-002: Parameter SYNC_STAGES, default 2, legal range 2..4: synchronizer depth for the asynchronous frame clocks.
- REQ-003: CLK  in  1  system clock; the block's only clock.
- REQ-004: reset  in  1  asynchronous, active-high reset.
- REQ-005: wclkIn  in  1  word clock from the ADC deserializer, asynchronous to CLK.
- REQ-006: lrckIn  in  1  channel select from the ADC deserializer, asynchronous to CLK; 1 = left word.
- REQ-007: leftIn  in  WIDTH  signed left sample from the ADC deserializer; changes only at wclkIn falling edges.
- REQ-008: rightIn  in  WIDTH  signed right sample from the ADC deserializer; changes only at wclkIn falling edges.
- REQ-009: leftOut  out  WIDTH  signed left sample of the presented stereo frame.
- REQ-010: rightOut  out  WIDTH  signed right sample of the presented stereo frame.
- REQ-011: outValid  out  1  a stereo frame is presented on leftOut/rightOut.
- REQ-012: outReady  in  1  the downstream stage accepts the frame in the current cycle.
- REQ-013: overflow  out  1  sticky flag: at least one completed frame was dropped.
- REQ-014: clearOverflow  in  1  synchronous clear of overflow.

Function
- REQ-015: wclkIn and lrckIn shall each pass through a SYNC_STAGES-deep flop chain in CLK, with reset value 0 on every flop.
- REQ-016: A word event shall be the cycle in which the synchronized wclk is 0 and its previous-cycle value is 1. Detection latency shall be SYNC_STAGES+1 CLK cycles after the wclkIn falling edge.
- REQ-017: In the word-event cycle, the block shall use the synchronized lrck value of that same cycle as the channel, and shall sample leftIn/rightIn directly.
- REQ-018: CLK frequency shall be at least 8x the wclkIn frequency. Under this condition the input buses are stable when sampled.
- REQ-019: The FSM shall have two states, WAIT_LEFT and WAIT_RIGHT.
- REQ-020: WAIT_LEFT, left event: capture leftIn into the hold register and go to WAIT_RIGHT.
- REQ-021: WAIT_LEFT, right event: discard the event and stay in WAIT_LEFT.
- REQ-022: WAIT_RIGHT, left event: overwrite the hold register with leftIn and stay in WAIT_RIGHT.
- REQ-023: WAIT_RIGHT, right event: complete the frame as {hold, rightIn} and go to WAIT_LEFT.
- REQ-024: Frame completion with outValid=0, or with outValid=1 and outReady=1 in the same cycle, shall load leftOut/rightOut on the next edge and leave outValid=1.
- REQ-025: Frame completion with outValid=1 and outReady=0 shall drop the new frame, keep the presented frame unchanged, and set overflow.
- REQ-026: outValid=1 and outReady=1 with no completion shall clear outValid on the next edge.
- REQ-027: While outValid=1, leftOut/rightOut shall not change until the frame is accepted.
- REQ-028: Latency from a right-word wclkIn falling edge to outValid=1 shall be SYNC_STAGES+2 CLK cycles.
- REQ-029: overflow shall stay 1 until clearOverflow=1. If clearOverflow coincides with a drop, overflow shall remain 1.
- REQ-030: Samples shall pass bit-exact: no arithmetic, no sign change, no truncation.

Reset
- REQ-031: While reset=1: leftOut=0, rightOut=0, outValid=0, overflow=0, hold register=0, all sync flops=0, FSM=WAIT_LEFT.
- REQ-032: Reset asserted mid-frame shall discard any held left sample.
- REQ-033: After reset deasserts, the first word event requires a 1->0 transition of the synchronized wclk. An input already low at deassertion shall not create an event.

Verification (SYNC_STAGES=2, WIDTH=16, CLK=16x wclk)
- REQ-034: Left word 0x1234, then right word 0xFEDC, with outReady=1 -> exactly one outValid pulse with leftOut=0x1234 and rightOut=0xFEDC, 4 CLK cycles after the right-word falling edge; overflow stays 0.
- REQ-035: Right word 0x7FFF first after reset, then left 0x8000, then right 0x0001 -> the first right word is dropped, and the only frame is {0x8000, 0x0001}.
- REQ-036: Two complete frames with outReady=0 throughout -> the first frame stays held, the second is dropped, and overflow=1; then clearOverflow pulse -> overflow=0 and the first frame is still presented.
- REQ-037: Left 0x1111, left 0x2222, then right 0x3333 -> frame {0x2222, 0x3333}.
- REQ-038: Reset asserted one CLK after a left-word event, deasserted with wclkIn low, then a right word 0x5555 -> no frame is produced, and outValid=0 throughout.
- REQ-039: Frame completion in the same cycle that outReady=1 accepts a presented frame -> outValid stays 1, the new data appears on the next edge, and overflow stays 0.
